seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Scan sequencer for the 4-digit 7-segment display on the CPU lab board.
//  Time-multiplexes one 16-bit hex value (a selected CPU register) across four digits.
//  Provides dead-time blanking between digits and tear-free frame-aligned sampling.
//  Sits between the register-select mux and the board pins (AN, Cathodes); runs on sysclk.
// PARAMETERS
//  SCAN_DIV   50000  sysclk cycles per digit slot (>= BLANK_CYC+2)
//  BLANK_CYC  16     cycles at start of each slot with all anodes off (anti-ghosting)
// PORTS
//  sysclk      in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  en          in   1   1 = scan; 0 = display dark, FSM idle
//  value       in   16  hex value; digit k shows value[4k+3:4k]
//  dp_mask     in   4   1 = light decimal point of digit k
//  an          out  4   digit anodes, active-low, registered
//  seg         out  7   segments gfedcba, active-low, registered
//  dp          out  1   decimal point, active-low, registered
//  frame_tick  out  1   1-cycle pulse when digit 3 slot ends (frame complete)
// BEHAVIOUR
//  Reset (async): an=4'hF, seg=7'h7F, dp=1, frame_tick=0, state=IDLE, digit=0, cnt=0, shadow=0.
//  FSM states: IDLE, BLANK, SHOW.
//   IDLE : outputs dark; en=1 -> BLANK, digit=0, cnt=0, shadow<=value, sdp<=dp_mask.
//   BLANK: an=4'hF; cnt++; cnt==BLANK_CYC-1 -> SHOW.
//   SHOW : an[digit]=0, others 1; seg=hex(shadow nibble); dp=~sdp[digit]; cnt++.
//          cnt==SCAN_DIV-1 -> BLANK, cnt=0, digit=digit+1 (mod 4).
//          If digit==3 at slot end: frame_tick=1 for that cycle; shadow/sdp reloaded from inputs.
//  value/dp_mask sampled only at frame start; changes mid-frame never appear until next frame.
//  Counter width $clog2(SCAN_DIV); cnt resets to 0 on every slot boundary, never overflows.
//  Registered outputs: state effects are visible on pins one sysclk after the transition.
//  en=0 in any state -> next cycle IDLE, an=4'hF, seg=7'h7F, dp=1, digit=0, no frame_tick.
//  Reset asserted mid-slot: immediate dark outputs; scan restarts from digit 0 after release.
//  Hex decode (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//                                   8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  seg/dp = 7'h7F/1 whenever an==4'hF.
// CONFIGURATION
//  `LEADING_ZERO_BLANK_EN defined:
//    In SHOW, digit k (k=3..1) stays dark (an=4'hF, seg=7'h7F, dp=1) if shadow[15:4k]==0.
//    Digit 0 is always shown. Slot timing and frame_tick are unchanged.
//  Not defined: all four digits are always shown (e.g. 0x0005 shows "0005").
// STRUCTURE
//  Package seg_pkg: state enum (IDLE/BLANK/SHOW), SEG_OFF=7'h7F, AN_OFF=4'hF, hex table constants.
//  Sub-module hex7seg: combinational 4-bit -> 7-bit active-low decoder, reusable elsewhere.
//  Top level: prescale counter, digit index, FSM, shadow registers, output registers.
// TESTING  (SCAN_DIV=8, BLANK_CYC=2)
//  1. Reset held, then released with en=0 -> an=F, seg=7F, dp=1 indefinitely; frame_tick never 1.
//  2. value=16'h1234, en=1 -> an sequence per 8-cycle slot: F,F then E x6 (seg=19), D (seg=30), B (24), 7 (79);
//     frame_tick pulses once every 32 cycles.
//  3. Change value to 16'hABCD while digit 1 is showing -> digits 2,3 still show 2,1;
//     next frame shows D,C,b,A.
//  4. dp_mask=4'b0100 -> dp=0 only while an=4'hB; dp=1 during blanking.
//  5. Drop en mid-SHOW of digit 2 -> next cycle an=F; re-raise en -> restart at digit 0
//     with fresh shadow. Assert reset mid-slot -> same-cycle dark outputs (async).
//  6. With LEADING_ZERO_BLANK_EN, value=16'h0005 -> only digit 0 lit (seg=12);
//     value=16'h0000 -> digit 0 shows 0 (seg=40).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low gfedcba patterns, entry k is the glyph for hex digit k (index 15 listed first).
  localparam logic [15:0][6:0] HEX_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit hex to active-low gfedcba segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_LUT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan sequencer time-multiplexing a 16-bit hex value over four active-low digits.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned     CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         digit_q, digit_d;
  logic [15:0]        shadow_q, shadow_d;
  logic [3:0]         sdp_q, sdp_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               tick_q, tick_d;

  logic [3:0]         nib_c;
  logic [6:0]         dec_seg_c;
  logic               lit_c;

  // Sequencing: slot counter runs through blank then show phases; frame ends after digit 3.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    tick_d   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      digit_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          cnt_d    = '0;
          digit_d  = 2'd0;
          shadow_d = value;
          sdp_d    = dp_mask;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd3) begin
              tick_d   = 1'b1;
              shadow_d = value;
              sdp_d    = dp_mask;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign nib_c = shadow_d[{digit_d, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (nib_c),
    .seg_c  (dec_seg_c)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign lit_c = (digit_d == 2'd0) || ((shadow_d >> {digit_d, 2'b00}) != 16'h0000);
`else
  assign lit_c = 1'b1;
`endif

  // Pin values are derived from next-state so the registered pins track the state register.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == SHOW && lit_c) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = dec_seg_c;
      dp_d  = ~sdp_d[digit_d];
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digit_q  <= 2'd0;
      shadow_q <= 16'h0000;
      sdp_q    <= 4'h0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (8-cycle slots, 32-cycle frames).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .sysclk     (clk),
    .reset      (reset),
    .en         (en),
    .value      (value),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Monitor: compare pins against the oldest expectation each sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if ({an, seg, dp, frame_tick} !== e) begin
          n_fail++;
          $display("FAIL pins #%0d: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                   n_tests, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
        end
      end
    end
  end

  task automatic cyc(input logic [3:0] a, input logic [6:0] s, input logic d, input logic t);
    exp_t e;
    @(posedge clk);
    #1;
    n_cyc++;
    e.an = a; e.seg = s; e.dp = d; e.tick = t;
    sb_q.push_back(e);
  endtask

  task automatic dark();
    cyc(4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  task automatic blank2(input logic t);
    cyc(4'hF, 7'h7F, 1'b1, t);
    cyc(4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  task automatic show(input int n, input logic [3:0] a, input logic [6:0] s, input logic d);
    for (int i = 0; i < n; i++) cyc(a, s, d, 1'b0);
  endtask

  task automatic slot(input logic t, input logic [3:0] a, input logic [6:0] s, input logic d);
    blank2(t);
    show(6, a, s, d);
  endtask

  task automatic frame(input logic t, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpm);
    slot(t,    4'hE, s0, ~dpm[0]);
    slot(1'b0, 4'hD, s1, ~dpm[1]);
    slot(1'b0, 4'hB, s2, ~dpm[2]);
    slot(1'b0, 4'h7, s3, ~dpm[3]);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; en = 1'b0; value = 16'h0000; dp_mask = 4'h0;
    repeat (3) dark();
    reset = 1'b0;
    repeat (6) dark();

    // Basic scan of 0x1234
    value = 16'h1234; en = 1'b1;
    frame(1'b0, 7'h19, 7'h30, 7'h24, 7'h79, 4'h0);

    // Value changes while digit 1 shows; rest of frame keeps old value
    slot(1'b1, 4'hE, 7'h19, 1'b1);
    blank2(1'b0);
    show(3, 4'hD, 7'h30, 1'b1);
    value = 16'hABCD;
    show(3, 4'hD, 7'h30, 1'b1);
    slot(1'b0, 4'hB, 7'h24, 1'b1);
    slot(1'b0, 4'h7, 7'h79, 1'b1);

    // New value appears; dp_mask changed mid-frame is deferred
    slot(1'b1, 4'hE, 7'h21, 1'b1);
    blank2(1'b0);
    dp_mask = 4'b0100;
    show(6, 4'hD, 7'h46, 1'b1);
    slot(1'b0, 4'hB, 7'h03, 1'b1);
    slot(1'b0, 4'h7, 7'h08, 1'b1);
    frame(1'b1, 7'h21, 7'h46, 7'h03, 7'h08, 4'b0100);

    // Drop en mid-show of digit 2, then restart from digit 0 with fresh shadow
    slot(1'b1, 4'hE, 7'h21, 1'b1);
    slot(1'b0, 4'hD, 7'h46, 1'b1);
    blank2(1'b0);
    show(2, 4'hB, 7'h03, 1'b0);
    en = 1'b0; value = 16'h9876; dp_mask = 4'b0001;
    repeat (4) dark();
    en = 1'b1;
    frame(1'b0, 7'h02, 7'h78, 7'h00, 7'h10, 4'b0001);

    // Async reset mid-slot darkens pins before the next edge
    blank2(1'b1);
    show(3, 4'hE, 7'h02, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
    sb_q.push_back(e);
    -> chk_ev;
    value = 16'h0005; dp_mask = 4'h0;
    repeat (2) dark();
    reset = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
    slot(1'b0, 4'hE, 7'h12, 1'b1);
    value = 16'h0000;
    slot(1'b0, 4'hF, 7'h7F, 1'b1);
    slot(1'b0, 4'hF, 7'h7F, 1'b1);
    slot(1'b0, 4'hF, 7'h7F, 1'b1);
    slot(1'b1, 4'hE, 7'h40, 1'b1);
    slot(1'b0, 4'hF, 7'h7F, 1'b1);
    slot(1'b0, 4'hF, 7'h7F, 1'b1);
    slot(1'b0, 4'hF, 7'h7F, 1'b1);
`else
    slot(1'b0, 4'hE, 7'h12, 1'b1);
    value = 16'h0000;
    slot(1'b0, 4'hD, 7'h40, 1'b1);
    slot(1'b0, 4'hB, 7'h40, 1'b1);
    slot(1'b0, 4'h7, 7'h40, 1'b1);
    frame(1'b1, 7'h40, 7'h40, 7'h40, 7'h40, 4'h0);
`endif
    blank2(1'b1);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
